// File: rtl/rx_sym_pkg.sv
// Shared 8b/10b K-code constants and the per-lane lock state type.
package rx_sym_pkg;

    localparam logic [7:0] K28_5_COM = 8'hBC;
    localparam logic [7:0] K27_7     = 8'hFB;
    localparam logic [7:0] K28_2     = 8'h5C;
    localparam logic [7:0] K28_0_SKP = 8'h1C;
    localparam logic [7:0] K29_7     = 8'hFD;
    localparam logic [7:0] K30_7     = 8'hFE;
    localparam logic [7:0] K28_1     = 8'h3C;
    localparam logic [7:0] K28_3     = 8'h7C;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    function automatic logic is_k_code(input logic [7:0] s);
        logic r;
        case (s)
            K28_5_COM, K27_7, K28_2, K28_0_SKP,
            K29_7, K30_7, K28_1, K28_3: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rx_lane_lock.sv
// One receive lane: K-symbol classifier, lock FSM, COM/error/gap counters.
// Optional SKP_STRIP_EN masks data_valid on SKP symbols of a locked lane.
module rx_lane_lock
    import rx_sym_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int MAX_ERR  = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic [7:0] i_data,
    input  logic       i_k,
    output logic [7:0] o_data,
    output logic       o_k,
    output logic       o_com_det,
    output logic       o_data_valid,
    output logic       o_locked
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(MAX_ERR + 1);
    localparam int GW = $clog2(TIMEOUT + 1);

    lock_state_e   r_state;
    logic [CW-1:0] r_com_cnt;
    logic [EW-1:0] r_err_cnt;
    logic [GW-1:0] r_gap;

    lock_state_e   w_state_nxt;
    logic [CW-1:0] w_com_nxt;
    logic [EW-1:0] w_err_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [GW-1:0] w_gap_inc;
    logic          w_is_com;
    logic          w_is_skp;
    logic          w_inv_k;
    logic          w_timeout;
    logic          w_valid;

    assign w_is_com  = i_k && (i_data == K28_5_COM);
    assign w_is_skp  = i_k && (i_data == K28_0_SKP);
    assign w_inv_k   = i_k && !is_k_code(i_data);
    assign w_gap_inc = (r_gap == GW'(TIMEOUT)) ? r_gap : r_gap + 1'b1;
    // A COM in the timeout cycle clears the gap, so it never times out.
    assign w_timeout = !w_is_com && (w_gap_inc == GW'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        w_com_nxt   = r_com_cnt;
        w_err_nxt   = r_err_cnt;
        w_gap_nxt   = w_is_com ? '0 : w_gap_inc;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_is_com) begin
                    w_state_nxt = ST_CHECK;
                    w_com_nxt   = CW'(1);
                end
            end
            ST_CHECK: begin
                if (w_is_com) begin
                    w_com_nxt = r_com_cnt + 1'b1;
                    if (r_com_cnt == CW'(LOCK_CNT - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_err_nxt   = '0;
                    end
                end else if (w_inv_k || w_timeout) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_com_nxt   = '0;
                    w_err_nxt   = '0;
                    w_gap_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                if (w_is_com) begin
                    w_err_nxt = '0;
                end else if (w_timeout || (w_inv_k && r_err_cnt >= EW'(MAX_ERR - 1))) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_com_nxt   = '0;
                    w_err_nxt   = '0;
                    w_gap_nxt   = '0;
                end else if (w_inv_k) begin
                    w_err_nxt = r_err_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
                w_com_nxt   = '0;
                w_err_nxt   = '0;
                w_gap_nxt   = '0;
            end
        endcase
    end

`ifdef SKP_STRIP_EN
    assign w_valid = (w_state_nxt == ST_LOCKED) && !w_is_skp;
`else
    assign w_valid = (w_state_nxt == ST_LOCKED);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_UNLOCKED;
            r_com_cnt    <= '0;
            r_err_cnt    <= '0;
            r_gap        <= '0;
            o_data       <= '0;
            o_k          <= 1'b0;
            o_com_det    <= 1'b0;
            o_data_valid <= 1'b0;
        end else if (enb) begin
            r_state      <= w_state_nxt;
            r_com_cnt    <= w_com_nxt;
            r_err_cnt    <= w_err_nxt;
            r_gap        <= w_gap_nxt;
            o_data       <= i_data;
            o_k          <= i_k;
            o_com_det    <= w_is_com;
            o_data_valid <= w_valid;
        end
    end

    assign o_locked = (r_state == ST_LOCKED);

endmodule

// File: rtl/rx_symbol_lock.sv
// Multi-lane symbol lock: LANES independent rx_lane_lock instances.
// Define SKP_STRIP_EN to drop data_valid on SKP symbols of locked lanes.
module rx_symbol_lock
    import rx_sym_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int LOCK_CNT = 4,
    parameter int MAX_ERR  = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic [8*LANES-1:0] rx_data,
    input  logic [LANES-1:0]   rx_k,
    output logic [8*LANES-1:0] data_out,
    output logic [LANES-1:0]   k_out,
    output logic [LANES-1:0]   com_det,
    output logic [LANES-1:0]   data_valid,
    output logic [LANES-1:0]   lane_locked,
    output logic               all_locked
);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        rx_lane_lock #(
            .LOCK_CNT (LOCK_CNT),
            .MAX_ERR  (MAX_ERR),
            .TIMEOUT  (TIMEOUT)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .enb          (enb),
            .i_data       (rx_data[8*n +: 8]),
            .i_k          (rx_k[n]),
            .o_data       (data_out[8*n +: 8]),
            .o_k          (k_out[n]),
            .o_com_det    (com_det[n]),
            .o_data_valid (data_valid[n]),
            .o_locked     (lane_locked[n])
        );
    end

    assign all_locked = &lane_locked;

endmodule

// File: doc/rx_symbol_lock.md
RX_SYMBOL_LOCK -- requirements
Module: rx_symbol_lock

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent 8-bit receive lanes (1..16).
REQ-002 SHALL have parameter LOCK_CNT, default 4, COM symbols required to declare lane lock (2..15).
REQ-003 SHALL have parameter MAX_ERR, default 4, invalid K symbols tolerated while locked before lock loss (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum enabled cycles between COMs before lock loss (>=LOCK_CNT).
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enb  input  1  cycle enable; when low, every register holds.
REQ-008 SHALL have port rx_data  input  8*LANES  received symbols, lane n at [8n+7:8n].
REQ-009 SHALL have port rx_k  input  LANES  per-lane control-symbol flag from the 8b/10b decoder.
REQ-010 SHALL have port data_out  output  8*LANES  registered copy of rx_data.
REQ-011 SHALL have port k_out  output  LANES  registered copy of rx_k.
REQ-012 SHALL have port com_det  output  LANES  lane carried COM (rx_k=1, 8'hBC) in the sampled cycle.
REQ-013 SHALL have port data_valid  output  LANES  lane symbol usable by downstream.
REQ-014 SHALL have port lane_locked  output  LANES  lane in LOCKED state.
REQ-015 SHALL have port all_locked  output  1  AND of lane_locked.

Function
REQ-016 SHALL classify, per lane, a symbol as valid K when rx_k=1 and value in {BC,FB,5C,1C,FD,FE,3C,7C}; invalid K when rx_k=1 otherwise; rx_k=0 is data, never an error.
REQ-017 SHALL present data_out, k_out, com_det, data_valid, lane_locked one cycle after sampling (latency 1, enb=1).
REQ-018 SHALL run a per-lane FSM UNLOCKED/CHECK/LOCKED, next state visible on lane_locked with the same symbol's data_out.
REQ-019 UNLOCKED: COM -> CHECK, com_cnt=1; anything else stays.
REQ-020 CHECK: COM increments com_cnt; com_cnt reaching LOCK_CNT -> LOCKED, err_cnt=0; invalid K -> UNLOCKED, com_cnt=0.
REQ-021 LOCKED: invalid K increments err_cnt (saturating); err_cnt reaching MAX_ERR -> UNLOCKED; COM clears err_cnt.
REQ-022 SHALL keep per-lane gap counter: cleared on COM, else +1 per enabled cycle, saturating at TIMEOUT; reaching TIMEOUT in CHECK or LOCKED -> UNLOCKED, counters cleared.
REQ-023 When timeout and COM coincide, COM wins (gap cleared, no transition to UNLOCKED).
REQ-024 data_valid SHALL equal the lane's next-state LOCKED, subject to REQ-030.
REQ-025 Lanes SHALL be fully independent; one lane's errors never affect another.
REQ-026 Counter widths SHALL be $clog2(param+1); no wrap-around permitted.

Reset
REQ-027 rst SHALL take priority over enb and force every FSM to UNLOCKED, all counters to 0.
REQ-028 Reset values: data_out 0, k_out 0, com_det 0, data_valid 0, lane_locked 0, all_locked 0.
REQ-029 Reset mid-lock SHALL drop lane_locked the cycle after rst; relock requires LOCK_CNT fresh COMs.

Configuration
REQ-030 With SKP_STRIP_EN defined, a LOCKED lane carrying SKP (rx_k=1, 8'h1C) SHALL output data_valid=0 for that symbol; FSM/counters unaffected. Without the macro, SKP follows REQ-024.

Structure
REQ-031 Package rx_sym_pkg SHALL hold the eight K-code constants and the lock-state enum.
REQ-032 Per-lane FSM, counters and classifier SHALL be sub-module rx_lane_lock, instantiated LANES times by generate.

Verification (LANES=4, LOCK_CNT=4, MAX_ERR=2, TIMEOUT=16)
REQ-033 Lane 0: 4 COMs spaced 8 cycles, data between -> lane_locked[0]=1 with 4th COM's data_out; others 0; all_locked=0.
REQ-034 All lanes locked, lane 2 two invalid K (rx_k=1, 8'h00) without COM between -> lane_locked[2]=0 after 2nd; all_locked=0; others stay locked.
REQ-035 Locked lane, 16 enabled cycles without COM -> UNLOCKED; COM exactly at cycle 16 -> stays locked.
REQ-036 Locked lane sends COM,SKP,SKP,SKP -> data_valid 1,0,0,0 with SKP_STRIP_EN; 1,1,1,1 without.
REQ-037 enb low 50 cycles while locked -> outputs frozen, no timeout; rst during CHECK (com_cnt=3) -> next COM gives com_cnt=1, no lock.
